// File: rtl/button_conditioner_if.sv
// Signal bundle between the board push-buttons and the button conditioner.
// The master side supplies tick and the raw buttons; the slave side returns the conditioned buttons.
interface button_conditioner_if;
  logic       tick;
  logic [4:0] btn_raw;
  logic [4:0] btn_pulse;
  logic [4:0] btn_level;

  modport master (output tick, output btn_raw, input btn_pulse, input btn_level);
  modport slave  (input tick, input btn_raw, output btn_pulse, output btn_level);
endinterface

// File: rtl/button_conditioner.sv
// Five independent button channels. Each channel has a synchroniser, a tick-based debounce,
// a press pulse, and an optional hold-to-repeat pulse train. Bit order is {U,D,R,L,C}.
module button_conditioner #(
  parameter int         DEB_TICKS = 4,
  parameter int         REP_DELAY = 200,
  parameter int         REP_RATE  = 50,
  parameter logic [4:0] REP_MASK  = 5'b11000
) (
  input  logic                clk,
  input  logic                rst,
  button_conditioner_if.slave bus
);
  localparam int DW   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_TICKS - 32'sd1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REP_DELAY - 32'sd1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REP_RATE - 32'sd1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD   = 2'b01,
    REPEAT = 2'b10
  } rep_state_e;

  logic [4:0] pulse_s;
  logic [4:0] level_s;

  for (genvar i = 0; i < 5; i++) begin : g_btn
    logic          s1_r, s2_r, stable_r, pulse_r;
    logic          stable_nxt_s, rise_s, hit_s;
    logic [DW-1:0] deb_cnt_r, deb_nxt_s;
    logic [RW-1:0] rep_cnt_r, rep_nxt_s;
    rep_state_e    state_r, state_nxt_s;

    // Debounce: the stable level flips only after DEB_TICKS consecutive disagreeing ticks.
    always_comb begin
      stable_nxt_s = stable_r;
      deb_nxt_s    = deb_cnt_r;
      if (bus.tick) begin
        if (s2_r == stable_r) begin
          deb_nxt_s = {DW{1'b0}};
        end else if (deb_cnt_r == DEB_LAST) begin
          stable_nxt_s = s2_r;
          deb_nxt_s    = {DW{1'b0}};
        end else begin
          deb_nxt_s = deb_cnt_r + DW'(1'b1);
        end
      end else begin
        deb_nxt_s = deb_cnt_r;
      end
    end

    assign rise_s = stable_nxt_s & ~stable_r;

    // Auto-repeat FSM; a release wins over a repeat pulse due on the same tick.
    always_comb begin
      state_nxt_s = state_r;
      rep_nxt_s   = rep_cnt_r;
      hit_s       = 1'b0;
      case (state_r)
        IDLE: begin
          if (rise_s && REP_MASK[i]) begin
            state_nxt_s = HOLD;
            rep_nxt_s   = {RW{1'b0}};
          end else begin
            state_nxt_s = IDLE;
          end
        end
        HOLD: begin
          if (!stable_nxt_s) begin
            state_nxt_s = IDLE;
            rep_nxt_s   = {RW{1'b0}};
          end else if (bus.tick) begin
            if (rep_cnt_r == DELAY_LAST) begin
              hit_s       = 1'b1;
              rep_nxt_s   = {RW{1'b0}};
              state_nxt_s = REPEAT;
            end else begin
              rep_nxt_s = rep_cnt_r + RW'(1'b1);
            end
          end else begin
            rep_nxt_s = rep_cnt_r;
          end
        end
        REPEAT: begin
          if (!stable_nxt_s) begin
            state_nxt_s = IDLE;
            rep_nxt_s   = {RW{1'b0}};
          end else if (bus.tick) begin
            if (rep_cnt_r == RATE_LAST) begin
              hit_s     = 1'b1;
              rep_nxt_s = {RW{1'b0}};
            end else begin
              rep_nxt_s = rep_cnt_r + RW'(1'b1);
            end
          end else begin
            rep_nxt_s = rep_cnt_r;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          rep_nxt_s   = {RW{1'b0}};
        end
      endcase
    end

    // Channel registers: synchroniser, debounce, repeat state and output pulse.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1_r      <= 1'b0;
        s2_r      <= 1'b0;
        stable_r  <= 1'b0;
        deb_cnt_r <= {DW{1'b0}};
        state_r   <= IDLE;
        rep_cnt_r <= {RW{1'b0}};
        pulse_r   <= 1'b0;
      end else begin
        s1_r      <= bus.btn_raw[i];
        s2_r      <= s1_r;
        stable_r  <= stable_nxt_s;
        deb_cnt_r <= deb_nxt_s;
        state_r   <= state_nxt_s;
        rep_cnt_r <= rep_nxt_s;
        pulse_r   <= rise_s | hit_s;
      end
    end

    assign pulse_s[i] = pulse_r;
    assign level_s[i] = stable_r;
  end

  assign bus.btn_pulse = pulse_s;
  assign bus.btn_level = level_s;
endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: scenario tasks plus a randomized run, all compared
// against a reference model that tracks disagreement run lengths and hold durations in ticks.
module tb_button_conditioner;
  localparam int         DEB  = 4;
  localparam int         DLY  = 5;
  localparam int         RATE = 2;
  localparam logic [4:0] MASK = 5'b11000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_v = 1'b0;

  button_conditioner_if bus();

  button_conditioner #(
    .DEB_TICKS(DEB), .REP_DELAY(DLY), .REP_RATE(RATE), .REP_MASK(MASK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int tick_no = 0;

  logic [4:0] exp_level, exp_pulse, h1, h2;
  int run[5];
  int held[5];
  bit pressed[5];

  task automatic model_clear();
    h1 = 5'h00; h2 = 5'h00; exp_level = 5'h00; exp_pulse = 5'h00;
    for (int i = 0; i < 5; i++) begin
      run[i] = 0; held[i] = 0; pressed[i] = 1'b0;
    end
  endtask

  // Reference: debounce sees the raw input two clocks late; repeats follow from the hold time.
  task automatic model_edge(input logic [4:0] raw, input bit tk);
    logic [4:0] dval;
    bit rose;
    dval = h2; h2 = h1; h1 = raw; exp_pulse = 5'h00;
    if (tk) begin
      for (int i = 0; i < 5; i++) begin
        rose = 1'b0;
        if (dval[i] == exp_level[i]) run[i] = 0;
        else begin
          run[i]++;
          if (run[i] == DEB) begin
            exp_level[i] = dval[i];
            run[i] = 0;
            rose = dval[i];
            pressed[i] = dval[i] && MASK[i];
            held[i] = 0;
            if (rose) exp_pulse[i] = 1'b1;
          end
        end
        if (!rose && pressed[i]) begin
          held[i]++;
          if (held[i] == DLY || (held[i] > DLY && (held[i] - DLY) % RATE == 0))
            exp_pulse[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic [4:0] raw, input bit tk);
    @(negedge clk);
    rst = rst_v;
    bus.btn_raw = raw;
    bus.tick = tk;
    @(posedge clk);
    if (rst) model_edge(raw, tk);
    else model_clear();
    if (tk) tick_no++;
    #1;
  endtask

  // Four clocks with the tick on the last, so any pulse is visible on return.
  task automatic period(input logic [4:0] raw);
    for (int c = 0; c < 4; c++) step(raw, c == 3);
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) period(5'h00);
  endtask

  task automatic test_reset();
    int cnt[5];
    int t0, lvl_t;
    rst_v = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step(5'h1F, c % 4 == 3);
      n_chk++;
      if (bus.btn_pulse !== 5'h00 || bus.btn_level !== 5'h00) begin
        n_fail++;
        $display("FAIL reset_hold pulse=%b level=%b expected 00000/00000", bus.btn_pulse, bus.btn_level);
      end
    end
    rst_v = 1'b1;
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    t0 = tick_no; lvl_t = -1;
    for (int c = 0; c < 28; c++) begin
      step(5'h1F, c % 4 == 3);
      n_chk++;
      if (bus.btn_pulse !== exp_pulse || bus.btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL reset_release_model pulse=%b/%b level=%b/%b", bus.btn_pulse, exp_pulse, bus.btn_level, exp_level);
      end
      for (int i = 0; i < 5; i++) if (bus.btn_pulse[i] === 1'b1) cnt[i]++;
      if (lvl_t < 0 && bus.btn_level === 5'h1F) lvl_t = tick_no - t0;
    end
    n_chk++;
    if (lvl_t !== 4) begin
      n_fail++;
      $display("FAIL reset_level_ticks got=%0d expected=4", lvl_t);
    end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (cnt[i] !== 1) begin
        n_fail++;
        $display("FAIL reset_press_count bit=%0d got=%0d expected=1", i, cnt[i]);
      end
    end
  endtask

  task automatic test_bounce();
    int cnt, t0, pt;
    settle(8);
    cnt = 0; pt = -1;
    for (int t = 0; t < 10; t++) begin
      period((t % 2 == 0) ? 5'h01 : 5'h00);
      n_chk++;
      if (bus.btn_pulse !== exp_pulse || bus.btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL bounce_model pulse=%b/%b level=%b/%b", bus.btn_pulse, exp_pulse, bus.btn_level, exp_level);
      end
      if (bus.btn_pulse[0] === 1'b1) cnt++;
    end
    t0 = tick_no;
    for (int t = 0; t < 8; t++) begin
      period(5'h01);
      n_chk++;
      if (bus.btn_pulse !== exp_pulse || bus.btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL bounce_model pulse=%b/%b level=%b/%b", bus.btn_pulse, exp_pulse, bus.btn_level, exp_level);
      end
      if (bus.btn_pulse[0] === 1'b1) begin
        cnt++;
        if (pt < 0) pt = tick_no - t0;
      end
    end
    n_chk++;
    if (cnt !== 1) begin
      n_fail++;
      $display("FAIL bounce_pulse_count got=%0d expected=1", cnt);
    end
    n_chk++;
    if (pt !== 4) begin
      n_fail++;
      $display("FAIL bounce_pulse_ticks got=%0d expected=4", pt);
    end
  endtask

  task automatic test_repeat();
    bit found, dropped;
    int reps, late;
    settle(8);
    found = 1'b0;
    for (int t = 0; t < 12 && !found; t++) begin
      period(5'h10);
      if (bus.btn_pulse[4] === 1'b1) found = 1'b1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL repeat_press_timeout got=none expected=press pulse");
    end
    reps = 0;
    for (int t = 0; t < 20; t++) begin
      period(5'h10);
      n_chk++;
      if (bus.btn_pulse !== exp_pulse || bus.btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL repeat_model pulse=%b/%b level=%b/%b", bus.btn_pulse, exp_pulse, bus.btn_level, exp_level);
      end
      if (bus.btn_pulse[4] === 1'b1) reps++;
    end
    n_chk++;
    if (reps !== 8) begin
      n_fail++;
      $display("FAIL repeat_count got=%0d expected=8", reps);
    end
    dropped = 1'b0; late = 0;
    for (int t = 0; t < 20; t++) begin
      period(5'h00);
      n_chk++;
      if (bus.btn_pulse !== exp_pulse || bus.btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL repeat_release_model pulse=%b/%b level=%b/%b", bus.btn_pulse, exp_pulse, bus.btn_level, exp_level);
      end
      if (bus.btn_level[4] === 1'b0) dropped = 1'b1;
      if (dropped && bus.btn_pulse[4] === 1'b1) late++;
    end
    n_chk++;
    if (!dropped || late !== 0) begin
      n_fail++;
      $display("FAIL repeat_release dropped=%0d pulses_after=%0d expected 1/0", dropped, late);
    end
  endtask

  task automatic test_no_repeat();
    int cnt, drops;
    bit up;
    settle(8);
    cnt = 0; drops = 0; up = 1'b0;
    for (int t = 0; t < 300; t++) begin
      period(5'h04);
      n_chk++;
      if (bus.btn_pulse !== exp_pulse || bus.btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL norep_model pulse=%b/%b level=%b/%b", bus.btn_pulse, exp_pulse, bus.btn_level, exp_level);
      end
      if (bus.btn_pulse[2] === 1'b1) cnt++;
      if (bus.btn_level[2] === 1'b1) up = 1'b1;
      else if (up) drops++;
    end
    n_chk++;
    if (cnt !== 1 || drops !== 0) begin
      n_fail++;
      $display("FAIL norep_r pulses=%0d drops=%0d expected 1/0", cnt, drops);
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] first;
    bit seen;
    settle(8);
    seen = 1'b0; first = 5'h00;
    for (int t = 0; t < 8; t++) begin
      period(5'h12);
      n_chk++;
      if (bus.btn_pulse !== exp_pulse || bus.btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL simul_model pulse=%b/%b level=%b/%b", bus.btn_pulse, exp_pulse, bus.btn_level, exp_level);
      end
      if (!seen && bus.btn_pulse !== 5'h00) begin
        seen = 1'b1;
        first = bus.btn_pulse;
      end
    end
    n_chk++;
    if (first !== 5'b10010) begin
      n_fail++;
      $display("FAIL simul_pulse got=%b expected=10010", first);
    end
  endtask

  task automatic test_reset_mid();
    int t0, p1, p2;
    settle(8);
    for (int t = 0; t < 12; t++) period(5'h10);
    @(negedge clk);
    rst = 1'b0; rst_v = 1'b0;
    model_clear();
    #1;
    n_chk++;
    if (bus.btn_pulse !== 5'h00 || bus.btn_level !== 5'h00) begin
      n_fail++;
      $display("FAIL midrst_async pulse=%b level=%b expected 00000/00000", bus.btn_pulse, bus.btn_level);
    end
    for (int t = 0; t < 3; t++) period(5'h10);
    n_chk++;
    if (bus.btn_pulse !== 5'h00 || bus.btn_level !== 5'h00) begin
      n_fail++;
      $display("FAIL midrst_hold pulse=%b level=%b expected 00000/00000", bus.btn_pulse, bus.btn_level);
    end
    rst_v = 1'b1;
    t0 = tick_no; p1 = -1; p2 = -1;
    for (int t = 0; t < 14; t++) begin
      period(5'h10);
      n_chk++;
      if (bus.btn_pulse !== exp_pulse || bus.btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL midrst_model pulse=%b/%b level=%b/%b", bus.btn_pulse, exp_pulse, bus.btn_level, exp_level);
      end
      if (bus.btn_pulse[4] === 1'b1) begin
        if (p1 < 0) p1 = tick_no - t0;
        else if (p2 < 0) p2 = tick_no - t0;
      end
    end
    n_chk++;
    if (p1 !== 4 || p2 !== 4 + DLY) begin
      n_fail++;
      $display("FAIL midrst_pulses first=%0d second=%0d expected 4/%0d", p1, p2, 4 + DLY);
    end
  endtask

  task automatic test_random();
    logic [4:0] r;
    bit tk;
    r = 5'h00;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0) r[$urandom_range(0, 4)] ^= 1'b1;
      tk = ($urandom_range(0, 2) == 0);
      step(r, tk);
      n_chk++;
      if (bus.btn_pulse !== exp_pulse || bus.btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d pulse=%b/%b level=%b/%b", c, bus.btn_pulse, exp_pulse, bus.btn_level, exp_level);
      end
    end
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.btn_raw = 5'h00;
    model_clear();
    test_reset();
    test_bounce();
    test_repeat();
    test_no_repeat();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
